// File: rtl/fa_pkg.sv
// fa_pkg: shared state encoding, default width and counter sizing for serial arithmetic cells
package fa_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  localparam int FA_W = 4;
  function automatic int cnt_w(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction
endpackage

// File: rtl/fs_cell.sv
// fs_cell: combinational full subtractor, mirror of the adder cell
module fs_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/serial_sub.sv
// serial_sub: bit-serial A-B, LSB first through one full-subtractor cell with registered borrow
module serial_sub
  import fa_pkg::*;
#(
  parameter int W = FA_W
) (
  input  logic         ck,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] b_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] d_out,
  output logic         bout
);
  localparam int CW = cnt_w(W);
  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           borrow_q, borrow_d;
  logic [W-1:0]   sa_q, sa_d, sb_q, sb_d, sd_q, sd_d, d_out_q, d_out_d;
  logic           bout_q, bout_d;
  logic           d, nb, last;
  fs_cell u_fs (
    .a    (sa_q[0]),
    .b    (sb_q[0]),
    .bin  (borrow_q),
    .d    (d),
    .bout (nb)
  );
  assign last      = cnt_q == CW'(W - 1);
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign d_out     = d_out_q;
  assign bout      = bout_q;
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    borrow_d = borrow_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    sd_d     = sd_q;
    d_out_d  = d_out_q;
    bout_d   = bout_q;
    case (state_q)
      IDLE: if (in_valid) begin
        sa_d     = a_in;
        sb_d     = b_in;
        borrow_d = 1'b0;
        cnt_d    = '0;
        state_d  = RUN;
      end
      RUN: begin
        sa_d     = sa_q >> 1;
        sb_d     = sb_q >> 1;
        sd_d     = {d, sd_q[W-1:1]};
        borrow_d = nb;
        cnt_d    = last ? '0 : cnt_q + CW'(1);
        if (last) begin
          d_out_d = sd_d;
          bout_d  = nb;
          state_d = DONE;
        end
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge ck) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      sa_q     <= '0;
      sb_q     <= '0;
      sd_q     <= '0;
      d_out_q  <= '0;
      bout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      borrow_q <= borrow_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      sd_q     <= sd_d;
      d_out_q  <= d_out_d;
      bout_q   <= bout_d;
    end
  end
endmodule

// File: tb/tb_serial_sub.sv
// tb_serial_sub: randomized self-checking bench for serial_sub against an arithmetic reference
module tb_serial_sub;
  localparam int W = 4;
  logic         ck = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] d_out;
  logic         bout;
  int           n_chk = 0;
  int           n_pass = 0;
  serial_sub #(.W(W)) dut (
    .ck        (ck),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d_out     (d_out),
    .bout      (bout)
  );
  always #5 ck = ~ck;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic run_op(input int a, input int b, input int hold, input bit pre);
    int lat;
    logic [W-1:0] exp_d;
    logic exp_b;
    exp_d = W'(a - b);
    exp_b = a < b;
    chk("idle_in_ready", 32'(in_ready), 1);
    in_valid  = 1'b1;
    a_in      = W'(a);
    b_in      = W'(b);
    out_ready = pre;
    @(negedge ck);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat <= 2 * W) begin
      chk("busy_in_ready", 32'(in_ready), 0);
      a_in     = W'($urandom);
      b_in     = W'($urandom);
      in_valid = 1'($urandom);
      @(negedge ck);
      lat++;
    end
    in_valid = 1'b0;
    chk("latency", 32'(lat), W);
    chk("d_out", 32'(d_out), 32'(exp_d));
    chk("bout", 32'(bout), 32'(exp_b));
    if (!pre) begin
      repeat (hold) begin
        in_valid = 1'($urandom);
        a_in     = W'($urandom);
        @(negedge ck);
        chk("hold_valid", 32'(out_valid), 1);
        chk("hold_d_out", 32'(d_out), 32'(exp_d));
        chk("hold_bout", 32'(bout), 32'(exp_b));
        chk("hold_in_ready", 32'(in_ready), 0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    @(negedge ck);
    out_ready = 1'b0;
    chk("post_valid", 32'(out_valid), 0);
    chk("post_in_ready", 32'(in_ready), 1);
  endtask
  initial begin
    repeat (2) @(negedge ck);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_d_out", 32'(d_out), 0);
    chk("rst_bout", 32'(bout), 0);
    rst = 1'b0;
    run_op(9, 3, 0, 0);
    run_op(3, 9, 0, 0);
    run_op(0, 15, 0, 0);
    run_op(15, 15, 0, 0);
    run_op(0, 0, 0, 0);
    run_op(10, 4, 5, 0);
    run_op(12, 5, 0, 0);
    run_op(7, 2, 0, 1);
    in_valid = 1'b1;
    a_in     = 4'd8;
    b_in     = 4'd1;
    @(negedge ck);
    in_valid = 1'b0;
    @(negedge ck);
    rst = 1'b1;
    @(negedge ck);
    rst = 1'b0;
    chk("mid_rst_in_ready", 32'(in_ready), 1);
    chk("mid_rst_d_out", 32'(d_out), 0);
    chk("mid_rst_bout", 32'(bout), 0);
    repeat (W + 2) begin
      chk("mid_rst_no_valid", 32'(out_valid), 0);
      @(negedge ck);
    end
    rst      = 1'b1;
    in_valid = 1'b1;
    a_in     = 4'd5;
    b_in     = 4'd2;
    @(negedge ck);
    rst      = 1'b0;
    in_valid = 1'b0;
    repeat (W + 2) begin
      @(negedge ck);
      chk("rst_vs_valid_idle", 32'(in_ready), 1);
      chk("rst_vs_valid_no_out", 32'(out_valid), 0);
    end
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++) begin
        repeat ($urandom_range(0, 2)) @(negedge ck);
        run_op(a, b, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/serial_sub.md
Name: serial_sub

Overview:
- Bit-serial subtractor; the inverse-operation companion to the team's registered full-adder cell.
- Accepts two parallel W-bit operands over a valid/ready handshake.
- Computes A − B LSB-first, one bit per clock, through a single full-subtractor cell with a registered borrow.
- Returns the parallel difference and borrow-out over a second valid/ready handshake.
- Sits between the operand source and the result consumer in the arithmetic datapath, where area beats throughput.

Parameters:
- W, 4, operand and difference width in bits; legal range 2..32.

Ports:
- ck  input  1  clock, rising edge; the only clock.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  operands a_in/b_in are valid.
- in_ready  output  1  block can accept operands; high only in IDLE.
- a_in  input  W  minuend.
- b_in  input  W  subtrahend.
- out_valid  output  1  d_out/bout are valid; high only in DONE.
- out_ready  input  1  consumer accepts the result.
- d_out  output  W  difference, A − B mod 2^W.
- bout  output  1  final borrow; 1 iff A < B unsigned.

Behaviour:
- Interface decision (already decided): one clock (ck); reset (rst) is synchronous and active-high.
- All state is registered. Every output is a register or a pure decode of the state register.
- Reset:
  - While rst is high at a rising ck edge: state = IDLE, cnt = 0, borrow = 0, shift registers = 0, d_out = 0, bout = 0.
  - Consequently out_valid = 0 and in_ready = 1 from the first cycle after reset.
  - rst has priority over every other input.
- States IDLE, RUN, DONE; encoding lives in the package.
- IDLE:
  - in_ready = 1.
  - On an edge with in_valid = 1: load sa <= a_in, sb <= b_in, clear borrow, cnt <= 0, go to RUN.
  - With in_valid = 0: hold.
- RUN:
  - in_ready = 0, out_valid = 0.
  - Each edge, the full-subtractor cell computes d = sa[0]^sb[0]^borrow and nb = (~sa[0]&sb[0]) | (~(sa[0]^sb[0])&borrow).
  - Then: sa and sb shift right by 1; the difference shift register shifts right with d inserted at the MSB; borrow <= nb; cnt <= cnt+1.
  - On the edge where cnt == W−1: d_out <= final difference, bout <= nb, go to DONE.
- DONE:
  - out_valid = 1; d_out and bout stay stable until the result is taken.
  - On an edge with out_ready = 1: go to IDLE.
  - in_valid is ignored in DONE; no same-cycle re-accept.
- Latency:
  - Operands accepted on edge k → out_valid high in the cycle after edge k+W, i.e. W cycles after the accept cycle.
  - Minimum initiation interval is W+2 cycles.
- Width rules:
  - cnt is clog2(W) bits and never exceeds W−1.
  - d_out equals (A − B) mod 2^W; bout is the borrow out of bit W−1.
- Boundary conditions:
  - A == B: d_out = 0, bout = 0.
  - A = 0, B = 2^W−1: d_out = 1, bout = 1.
  - Inputs toggling during RUN/DONE have no effect; operands are captured only on the accept edge.
  - out_ready held high before DONE: result is consumed on the first DONE edge; out_valid is high for exactly one cycle.
  - Reset mid-RUN or mid-DONE: result is discarded, no out_valid pulse, block is back in IDLE the next cycle.
  - in_valid and rst high on the same edge: reset wins, nothing is accepted.

Decomposition:
- Package fa_pkg holds:
  - state enum (IDLE, RUN, DONE);
  - default width constant FA_W = 4;
  - counter-width function.
- One natural sub-module: fs_cell, a purely combinational full subtractor.
  - Inputs a, b, bin; outputs d, bout.
  - Instantiated once; it is the mirror of the team's existing adder cell.

Test Plan:
- Basic subtract (W=4): reset 2 cycles, then a_in=9, b_in=3, in_valid for 1 cycle → out_valid exactly 4 cycles after the accept cycle, d_out=6, bout=0; in_ready=0 until the handshake completes.
- Underflow: a_in=3, b_in=9 → d_out=10 (0xA), bout=1.
- Edge operands:
  - a_in=0, b_in=15 → d_out=1, bout=1.
  - a_in=15, b_in=15 → d_out=0, bout=0.
  - a_in=0, b_in=0 → d_out=0, bout=0.
- Output backpressure: hold out_ready=0 for 5 cycles in DONE → out_valid and d_out stay stable and in_ready stays 0. Raise out_ready → IDLE next cycle. Then issue a back-to-back second op 12−5 → d_out=7.
- Reset mid-operation: assert rst two cycles after accepting 8−1 → out_valid never rises, d_out=0, in_ready=1 the cycle after reset.
- Randomized sweep: all 256 (A,B) pairs at W=4 with random in_valid/out_ready gaps → every result matches (A−B) mod 16 and borrow matches A<B.
